// File: rtl/bpred_pkg.sv
// Shared types and helpers for the branch-predictor counter table.
package bpred_pkg;

  // Index width the queue entry type is sized for; the controller's IDX_W defaults to it.
  localparam int unsigned BpIdxW = 6;

  typedef enum logic [1:0] {
    CntSnt = 2'd0,
    CntWnt = 2'd1,
    CntWt  = 2'd2,
    CntSt  = 2'd3
  } cnt_e;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  typedef struct packed {
    logic [BpIdxW-1:0] idx;
    logic              taken;
  } upd_entry_t;

  // Two-bit saturating counter step toward the resolved direction.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != CntSt) res = cnt + 2'd1;
    end else begin
      if (cnt != CntSnt) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// In-order queue of pending counter updates; power-of-two depth, wrapping pointers.
module bpred_upd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 7
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  // Pointer and occupancy next-state; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q + {{(PtrW-1){1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{(PtrW-1){1'b0}}, pop_ok};
    count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  // Pointer and count state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Status and head outputs.
  always_comb begin
    data_o  = mem_q[rd_ptr_q];
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
  end

endmodule

// File: rtl/bpred_table_ctrl.sv
// Branch counter table: post-reset init sweep, then one access per cycle shared
// between lookups (priority) and queued resolution updates (with starvation override).
module bpred_table_ctrl
  import bpred_pkg::*;
#(
  parameter int unsigned IDX_W      = BpIdxW,
  parameter logic [1:0]  INIT_STATE = 2'd3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_WAIT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_idx,
  output logic             req_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_taken,
  output logic             res_ready,
  output logic             init_busy
);

  localparam int unsigned Depth = 2 ** IDX_W;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [1:0]       table_q [Depth];

  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [1:0]       tbl_wdata;

  upd_entry_t       push_entry, head_entry;
  logic             fifo_full, fifo_empty;
  logic             force_pop, lookup, pop, push;

  assign push_entry = '{idx: res_idx, taken: res_taken};

  bpred_upd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width ($bits(upd_entry_t))
  ) u_upd_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StInit;
    else        state_q <= state_d;
  end

  // FSM next state: leave init once the last entry has been written.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  if (init_ptr_q == IDX_W'(Depth - 1)) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // FSM outputs and port arbitration; lookups win unless the head has waited too long.
  always_comb begin
    force_pop = !fifo_empty && (wait_cnt_q == WaitW'(MAX_WAIT));
    init_busy = 1'b0;
    req_ready = 1'b0;
    res_ready = 1'b0;
    unique case (state_q)
      StInit: init_busy = 1'b1;
      StRun: begin
        req_ready = !force_pop;
        res_ready = !fifo_full;
      end
      default: init_busy = 1'b1;
    endcase
    lookup = req_valid && req_ready;
    push   = res_valid && res_ready;
    pop    = (state_q == StRun) && !lookup && !fifo_empty;
  end

  // Datapath next state: table write port, init pointer, head wait counter, prediction.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    if (state_q == StInit) begin
      tbl_we    = 1'b1;
      tbl_waddr = init_ptr_q;
      tbl_wdata = INIT_STATE;
    end else if (pop) begin
      tbl_we    = 1'b1;
      tbl_waddr = head_entry.idx;
      tbl_wdata = sat_update(table_q[head_entry.idx], head_entry.taken);
    end

    init_ptr_d = (state_q == StInit) ? init_ptr_q + 1'b1 : init_ptr_q;

    if (state_q != StRun || fifo_empty || pop) wait_cnt_d = '0;
    else                                       wait_cnt_d = wait_cnt_q + 1'b1;

    pred_valid_d = lookup;
    pred_taken_d = lookup ? table_q[req_idx][1] : pred_taken_q;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_ptr_q   <= '0;
      wait_cnt_q   <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      init_ptr_q   <= init_ptr_d;
      wait_cnt_q   <= wait_cnt_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
    end
  end

  // Counter table; the post-reset sweep defines its contents.
  always_ff @(posedge clk) begin
    if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;

endmodule
